front_panel_loader: RTL and testbench

- Upstream front-panel stage of the 8-bit CPU.
- Debounces the active-low 4-way stick, builds 13-bit instruction words from the 8 switches, and writes them into program memory through a single-cycle write port.
- Owns the CPU run/halt control (`cpu_rst_o`) and the panel address shown on the LEDs while the CPU is halted.
- Replaces the inline panel state machine with a clean, single-clock, handshaked block.

---
 rtl/cpu_pkg.sv | 19 +
 rtl/stick_debounce.sv | 46 ++++
 rtl/front_panel_loader.sv | 113 +++++++++++
 tb/tb_front_panel_loader.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared constants for the front-panel loader
package cpu_pkg;

  localparam int DEF_WORD_W = 13;
  localparam int DEF_ADDR_W = 7;

  localparam int STK_RUN  = 0;
  localparam int STK_LOAD = 1;
  localparam int STK_DEC  = 2;
  localparam int STK_INC  = 3;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD_HI = 3'd1,
    COMMIT  = 3'd2,
    RUN     = 3'd3
  } fp_state_t;

endpackage

// File: rtl/stick_debounce.sv
// rtl/stick_debounce.sv - one active-low stick line: tick-sampled debounce and press pulse
module stick_debounce #(
  parameter int DB_TICKS = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic tick_i,
  input  logic raw_i,
  output logic press_o
);

  localparam int CNT_W = $clog2(DB_TICKS + 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_stable;
  logic             r_press;
  logic             w_differ;
  logic             w_accept;

  assign w_differ = (raw_i != r_stable);
  // The tick that would take the counter to DB_TICKS is the one that accepts the new level.
  assign w_accept = tick_i && w_differ && (r_cnt == CNT_W'(DB_TICKS - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt    <= '0;
      r_stable <= 1'b1;
      r_press  <= 1'b0;
    end else begin
      r_press <= w_accept && !raw_i;
      if (tick_i) begin
        if (!w_differ) begin
          r_cnt <= '0;
        end else if (w_accept) begin
          r_stable <= raw_i;
          r_cnt    <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  assign press_o = r_press;

endmodule

// File: rtl/front_panel_loader.sv
// rtl/front_panel_loader.sv - panel FSM writing switch words into program memory; FRONT_PANEL_AUTOINC_EN steps the address after each write
module front_panel_loader
  import cpu_pkg::*;
#(
  parameter int WORD_W   = DEF_WORD_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DB_TICKS = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              tick_i,
  input  logic [7:0]        switches_i,
  input  logic [3:0]        stick_i,
  output logic              mem_wr_en_o,
  output logic [ADDR_W-1:0] mem_wr_addr_o,
  output logic [WORD_W-1:0] mem_wr_data_o,
  output logic              cpu_rst_o,
  output logic [ADDR_W-1:0] panel_addr_o,
  output logic [2:0]        state_o
);

  logic [3:0]        w_press;
  fp_state_t         r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_panel_addr, w_addr_nxt;
  logic              r_cpu_rst, w_cpu_rst_nxt;
  logic [7:0]        r_lower, w_lower_nxt;
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [WORD_W-1:0] r_wr_data;

  for (genvar g = 0; g < 4; g++) begin : g_db
    stick_debounce #(.DB_TICKS(DB_TICKS)) u_db (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .tick_i  (tick_i),
      .raw_i   (stick_i[g]),
      .press_o (w_press[g])
    );
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_addr_nxt    = r_panel_addr;
    w_cpu_rst_nxt = r_cpu_rst;
    w_lower_nxt   = r_lower;
    case (r_state)
      IDLE: begin
        if (w_press[STK_DEC]) begin
          w_addr_nxt = r_panel_addr - 1'b1;
        end else if (w_press[STK_INC]) begin
          w_addr_nxt = r_panel_addr + 1'b1;
        end else if (w_press[STK_LOAD]) begin
          w_lower_nxt = switches_i;
          w_state_nxt = LOAD_HI;
        end else if (w_press[STK_RUN]) begin
          w_cpu_rst_nxt = 1'b0;
          w_state_nxt   = RUN;
        end
      end
      LOAD_HI: begin
        if (w_press[STK_LOAD]) begin
          w_state_nxt = COMMIT;
        end else if (w_press[STK_RUN]) begin
          w_state_nxt = IDLE;
        end
      end
      COMMIT: begin
        w_state_nxt = IDLE;
`ifdef FRONT_PANEL_AUTOINC_EN
        w_addr_nxt = r_panel_addr + 1'b1;
`endif
      end
      RUN: begin
        if (w_press[STK_LOAD]) begin
          w_cpu_rst_nxt = 1'b1;
          w_state_nxt   = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state      <= IDLE;
      r_panel_addr <= '0;
      r_cpu_rst    <= 1'b1;
      r_lower      <= '0;
      r_wr_en      <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_panel_addr <= w_addr_nxt;
      r_cpu_rst    <= w_cpu_rst_nxt;
      r_lower      <= w_lower_nxt;
      // Strobe is registered so it is high exactly while the FSM sits in COMMIT.
      r_wr_en      <= (w_state_nxt == COMMIT);
      if (r_state == LOAD_HI && w_state_nxt == COMMIT) begin
        r_wr_addr <= r_panel_addr;
        r_wr_data <= {switches_i[WORD_W-9:0], r_lower};
      end
    end
  end

  assign mem_wr_en_o   = r_wr_en;
  assign mem_wr_addr_o = r_wr_addr;
  assign mem_wr_data_o = r_wr_data;
  assign cpu_rst_o     = r_cpu_rst;
  assign panel_addr_o  = r_panel_addr;
  assign state_o       = r_state;

endmodule

// File: tb/tb_front_panel_loader.sv
// tb/tb_front_panel_loader.sv - scoreboard bench for front_panel_loader
module tb_front_panel_loader;

  localparam int WORD_W = 13;
  localparam int ADDR_W = 7;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              tick = 1'b0;
  logic [7:0]        sw = 8'h00;
  logic [3:0]        stick = 4'hF;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [WORD_W-1:0] wr_data;
  logic              cpu_rst;
  logic [ADDR_W-1:0] panel_addr;
  logic [2:0]        state;

  int checks = 0;
  int errors = 0;
  int writes_seen = 0;
  int writes_exp = 0;
  logic [ADDR_W+WORD_W-1:0] exp_q[$];
  logic [ADDR_W-1:0] exp_addr;

  front_panel_loader dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .tick_i        (tick),
    .switches_i    (sw),
    .stick_i       (stick),
    .mem_wr_en_o   (wr_en),
    .mem_wr_addr_o (wr_addr),
    .mem_wr_data_o (wr_data),
    .cpu_rst_o     (cpu_rst),
    .panel_addr_o  (panel_addr),
    .state_o       (state)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired actual=timeout required=finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && wr_en) begin
      logic [ADDR_W+WORD_W-1:0] e;
      writes_seen++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write actual=%0h/%0h required=none", wr_addr, wr_data);
      end else begin
        e = exp_q.pop_front();
        if ({wr_addr, wr_data} !== e) begin
          errors++;
          $display("FAIL write actual=%0h/%0h required=%0h/%0h", wr_addr, wr_data,
                   e[ADDR_W+WORD_W-1:WORD_W], e[WORD_W-1:0]);
        end
      end
    end
  end

  task automatic do_ticks(input int n);
    repeat (n) begin
      @(posedge clk); #1 tick = 1'b1;
      @(posedge clk); #1 tick = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  task automatic press(input logic [3:0] mask);
    stick = 4'hF & ~mask;
    do_ticks(5);
    stick = 4'hF;
    do_ticks(5);
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic check_reset_vals(input string tag);
    sample();
    check({tag, "_panel_addr"}, 32'(panel_addr), 32'd0);
    check({tag, "_cpu_rst"}, 32'(cpu_rst), 32'd1);
    check({tag, "_state"}, 32'(state), 32'd0);
    check({tag, "_wr_en"}, 32'(wr_en), 32'd0);
    check({tag, "_wr_addr"}, 32'(wr_addr), 32'd0);
    check({tag, "_wr_data"}, 32'(wr_data), 32'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    check_reset_vals("reset");
    @(posedge clk); #1 rst = 1'b0;
    do_ticks(100);
    sample();
    check("idle_cpu_rst", 32'(cpu_rst), 32'd1);
    check("idle_state", 32'(state), 32'd0);

    press(4'b0100);
    sample(); check("dec_wrap", 32'(panel_addr), 32'd127);
    press(4'b1000);
    press(4'b1000);
    sample(); check("inc_wrap", 32'(panel_addr), 32'd1);

    repeat (4) press(4'b1000);
    sample(); check("addr5", 32'(panel_addr), 32'd5);
    sw = 8'hA5;
    press(4'b0010);
    sample(); check("load_hi_state", 32'(state), 32'd1);
    sw = 8'h13;
    exp_q.push_back({7'd5, 13'h13A5});
    writes_exp++;
    press(4'b0010);
    sample(); check("after_commit_state", 32'(state), 32'd0);
`ifdef FRONT_PANEL_AUTOINC_EN
    exp_addr = 7'd6;
`else
    exp_addr = 7'd5;
`endif
    check("after_commit_addr", 32'(panel_addr), 32'(exp_addr));
    check("wr_data_hold", 32'(wr_data), 32'h13A5);
    check("wr_addr_hold", 32'(wr_addr), 32'd5);

    for (int i = 0; i < 6; i++) begin
      stick = (i % 2 == 0) ? 4'b1011 : 4'b1111;
      do_ticks(2);
    end
    stick = 4'hF;
    do_ticks(5);
    sample(); check("bounce_ignored", 32'(panel_addr), 32'(exp_addr));
    press(4'b1100);
    exp_addr = exp_addr - 1'b1;
    sample(); check("dec_over_inc", 32'(panel_addr), 32'(exp_addr));

    press(4'b0001);
    sample();
    check("run_cpu_rst", 32'(cpu_rst), 32'd0);
    check("run_state", 32'(state), 32'd3);
    press(4'b0100);
    press(4'b1000);
    press(4'b0001);
    sample();
    check("run_addr_hold", 32'(panel_addr), 32'(exp_addr));
    check("run_state_hold", 32'(state), 32'd3);
    press(4'b0010);
    sample();
    check("stop_cpu_rst", 32'(cpu_rst), 32'd1);
    check("stop_state", 32'(state), 32'd0);

    sw = 8'h3C;
    press(4'b0010);
    sample(); check("abort_load_hi", 32'(state), 32'd1);
    press(4'b0001);
    sample();
    check("abort_state", 32'(state), 32'd0);
    check("abort_cpu_rst", 32'(cpu_rst), 32'd1);

    press(4'b0010);
    sample(); check("rst_load_hi", 32'(state), 32'd1);
    #1 rst = 1'b1;
    check_reset_vals("midrst");
    @(posedge clk); #1 rst = 1'b0;
    do_ticks(10);
    sample(); check("post_rst_state", 32'(state), 32'd0);

    check("writes_count", 32'(writes_seen), 32'(writes_exp));
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
